// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Single-port flop-array memory behind a valid/ready request
//            channel and a valid/ready response channel. Adds byte enables,
//            configurable wait states, response back-pressure, out-of-range
//            error reporting and a saturating count of successful accesses.
// Ports    : clk, rst_n                 clock / async active-low reset
//            req_valid/req_ready        request handshake
//            req_write, req_addr,       request command, word address,
//            req_wdata, req_be          write data and byte enables
//            rsp_valid/rsp_ready        response handshake
//            rsp_rdata, rsp_err         read data (0 on write/error), error
//            busy                       high whenever not idle
//            access_count               successful transactions, saturating
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int WAIT_CYCLES = 2,
  parameter int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           access_count
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // The WAIT counter is loaded with WAIT_CYCLES-1 and leaves at zero, so the
  // block spends exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [1:0]            state;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] merged;

  // The extra address bit lets the master reach addresses >= DEPTH; the
  // truncated index is only used when the full address is in range.
  assign in_range = (32'(addr_q) < 32'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];

  // Byte-granular merge of captured write data over the current word.
  generate
    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_byte
      assign merged[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8] : mem[idx][b*8 +: 8];
    end
  endgenerate

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      wait_cnt     <= 4'd0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      access_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          rsp_err   <= ~in_range;
          rsp_rdata <= (in_range && !wr_q) ? mem[idx] : '0;
          if (WAIT_CYCLES == 0) begin
            state <= ST_DONE;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          // Response fields stay frozen until the master takes them.
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (!rsp_err && access_count != COUNT_MAX) begin
              access_count <= access_count + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage: cleared on reset, written once per transaction in ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ST_ACTIVE && wr_q && in_range) begin
      mem[idx] <= merged;
    end
  end

endmodule
`default_nettype wire
